// File: rtl/traceback_unit_pkg.sv
// Shared encodings for the traceback unit: FSM states, direction-code fields,
// H-source codes, op codes and the DP-matrix identifiers.
package traceback_unit_pkg;
  localparam int TB_N      = 4;
  localparam int TB_LOG_N  = 2;
  localparam int TB_ADDR_W = 8;
  localparam int TB_BLK_W  = 6;
  localparam int DIR_W     = 5;

  localparam int BIT_SHORT_EXT = 3;
  localparam int BIT_LONG_EXT  = 4;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_ADDR   = 3'd1;
  localparam logic [2:0] ST_WAIT   = 3'd2;
  localparam logic [2:0] ST_DECODE = 3'd3;
  localparam logic [2:0] ST_EMIT   = 3'd4;
  localparam logic [2:0] ST_DONE   = 3'd5;

  localparam logic [2:0] SRC_STOP  = 3'd0;
  localparam logic [2:0] SRC_DIAG  = 3'd1;
  localparam logic [2:0] SRC_E     = 3'd2;
  localparam logic [2:0] SRC_F     = 3'd3;
  localparam logic [2:0] SRC_E_HAT = 3'd4;
  localparam logic [2:0] SRC_F_HAT = 3'd5;

  localparam logic [1:0] OP_MATCH = 2'd0;
  localparam logic [1:0] OP_INS   = 2'd1;
  localparam logic [1:0] OP_DEL   = 2'd2;

  typedef enum logic [2:0] {
    MAT_H     = 3'd0,
    MAT_E     = 3'd1,
    MAT_F     = 3'd2,
    MAT_E_HAT = 3'd3,
    MAT_F_HAT = 3'd4
  } matrix_t;
endpackage

// File: rtl/tb_dir_decode.sv
// Combinational decode of one direction code in the current matrix into the
// traceback step: stop flag, op, coordinate decrements and the next matrix.
module tb_dir_decode
  import traceback_unit_pkg::*;
(
  input  logic [DIR_W-1:0] code,
  input  matrix_t          matrix,
  output logic             stop,
  output logic [1:0]       op,
  output logic             dx,
  output logic             dy,
  output matrix_t          next_matrix
);
  matrix_t eff_matrix_s;

  // An H cell pointing into a gap matrix is re-evaluated there in the same cycle.
  always_comb begin
    eff_matrix_s = matrix;
    if (matrix == MAT_H) begin
      case (code[2:0])
        SRC_E:     eff_matrix_s = MAT_E;
        SRC_F:     eff_matrix_s = MAT_F;
        SRC_E_HAT: eff_matrix_s = MAT_E_HAT;
        SRC_F_HAT: eff_matrix_s = MAT_F_HAT;
        default:   eff_matrix_s = MAT_H;
      endcase
    end else begin
      eff_matrix_s = matrix;
    end

    stop        = 1'b0;
    op          = OP_MATCH;
    dx          = 1'b0;
    dy          = 1'b0;
    next_matrix = MAT_H;
    case (eff_matrix_s)
      MAT_H: begin
        if (code[2:0] == SRC_DIAG) begin
          dx = 1'b1;
          dy = 1'b1;
        end else begin
          stop = 1'b1;
        end
      end
      MAT_E: begin
        op          = OP_DEL;
        dx          = 1'b1;
        next_matrix = code[BIT_SHORT_EXT] ? MAT_E : MAT_H;
      end
      MAT_E_HAT: begin
        op          = OP_DEL;
        dx          = 1'b1;
        next_matrix = code[BIT_LONG_EXT] ? MAT_E_HAT : MAT_H;
      end
      MAT_F: begin
        op          = OP_INS;
        dy          = 1'b1;
        next_matrix = code[BIT_SHORT_EXT] ? MAT_F : MAT_H;
      end
      MAT_F_HAT: begin
        op          = OP_INS;
        dy          = 1'b1;
        next_matrix = code[BIT_LONG_EXT] ? MAT_F_HAT : MAT_H;
      end
      default: stop = 1'b1;
    endcase
  end
endmodule

// File: rtl/traceback_unit.sv
// Walks the direction RAMs back from the best cell, emitting one alignment op
// per step through a valid/ready handshake.
module traceback_unit
  import traceback_unit_pkg::*;
#(
  parameter int N      = TB_N,
  parameter int LOG_N  = TB_LOG_N,
  parameter int ADDR_W = TB_ADDR_W,
  parameter int BLK_W  = TB_BLK_W
) (
  input  logic               clk,
  input  logic               reset_i,
  input  logic               start,
  input  logic [ADDR_W-1:0]  tb_x,
  input  logic [ADDR_W-1:0]  tb_y,
  input  logic [N*5-1:0]     column_k0,
  output logic [BLK_W-1:0]   mem_block_num,
  output logic [ADDR_W-1:0]  column_num,
  output logic               op_valid,
  output logic [1:0]         op,
  input  logic               op_ready,
  output logic               busy,
  output logic               done,
  output logic [ADDR_W:0]    path_len
);
  logic [2:0]        state_r, state_next_s;
  logic [ADDR_W-1:0] x_r, y_r, x_next_s, y_next_s, pend_x_r, pend_y_r;
  matrix_t           matrix_r, matrix_next_s, pend_matrix_r, dec_matrix_s;
  logic              dec_stop_s, dec_dx_s, dec_dy_s;
  logic [1:0]        dec_op_s, op_r;
  logic [LOG_N-1:0]  lane_s;
  logic [DIR_W-1:0]  code_s;
  logic              op_valid_r, busy_r, done_r;
  logic [ADDR_W:0]   path_len_r;
  logic [BLK_W-1:0]  mem_block_num_r;
  logic [ADDR_W-1:0] column_num_r;

  assign lane_s = y_r[LOG_N-1:0];
  assign code_s = column_k0[lane_s*DIR_W +: DIR_W];

  tb_dir_decode u_dec (
    .code        (code_s),
    .matrix      (matrix_r),
    .stop        (dec_stop_s),
    .op          (dec_op_s),
    .dx          (dec_dx_s),
    .dy          (dec_dy_s),
    .next_matrix (dec_matrix_s)
  );

  // Next-state and next-coordinate selection.
  always_comb begin
    state_next_s  = state_r;
    x_next_s      = x_r;
    y_next_s      = y_r;
    matrix_next_s = matrix_r;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          state_next_s  = ST_ADDR;
          x_next_s      = tb_x;
          y_next_s      = tb_y;
          matrix_next_s = MAT_H;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_ADDR: state_next_s = ST_WAIT;
      ST_WAIT: state_next_s = ST_DECODE;
      ST_DECODE: begin
        // A zero coordinate also covers any gap step that would go negative.
        if ((x_r == {ADDR_W{1'b0}}) || (y_r == {ADDR_W{1'b0}}) || dec_stop_s) begin
          state_next_s = ST_DONE;
        end else begin
          state_next_s = ST_EMIT;
        end
      end
      ST_EMIT: begin
        if (op_ready) begin
          state_next_s  = ST_ADDR;
          x_next_s      = pend_x_r;
          y_next_s      = pend_y_r;
          matrix_next_s = pend_matrix_r;
        end else begin
          state_next_s = ST_EMIT;
        end
      end
      ST_DONE: state_next_s = ST_IDLE;
      default: state_next_s = ST_IDLE;
    endcase
  end

  // State, coordinates and all registered outputs.
  always_ff @(posedge clk or negedge reset_i) begin
    if (!reset_i) begin
      state_r         <= ST_IDLE;
      x_r             <= {ADDR_W{1'b0}};
      y_r             <= {ADDR_W{1'b0}};
      matrix_r        <= MAT_H;
      pend_x_r        <= {ADDR_W{1'b0}};
      pend_y_r        <= {ADDR_W{1'b0}};
      pend_matrix_r   <= MAT_H;
      op_r            <= OP_MATCH;
      op_valid_r      <= 1'b0;
      busy_r          <= 1'b0;
      done_r          <= 1'b0;
      path_len_r      <= {(ADDR_W+1){1'b0}};
      mem_block_num_r <= {BLK_W{1'b0}};
      column_num_r    <= {ADDR_W{1'b0}};
    end else begin
      state_r    <= state_next_s;
      x_r        <= x_next_s;
      y_r        <= y_next_s;
      matrix_r   <= matrix_next_s;
      op_valid_r <= (state_next_s == ST_EMIT);
      busy_r     <= (state_next_s != ST_IDLE);
      done_r     <= (state_next_s == ST_DONE);
      if ((state_r == ST_IDLE) && start) begin
        path_len_r <= {(ADDR_W+1){1'b0}};
      end else if ((state_r == ST_EMIT) && op_ready) begin
        path_len_r <= path_len_r + (ADDR_W+1)'(1);
      end
      if (state_next_s == ST_ADDR) begin
        column_num_r    <= x_next_s;
        mem_block_num_r <= BLK_W'(y_next_s >> LOG_N);
      end
      if (state_r == ST_DECODE) begin
        op_r          <= dec_op_s;
        pend_x_r      <= x_r - ADDR_W'(dec_dx_s);
        pend_y_r      <= y_r - ADDR_W'(dec_dy_s);
        pend_matrix_r <= dec_matrix_s;
      end
    end
  end

  assign op_valid      = op_valid_r;
  assign op            = op_r;
  assign busy          = busy_r;
  assign done          = done_r;
  assign path_len      = path_len_r;
  assign mem_block_num = mem_block_num_r;
  assign column_num    = column_num_r;
endmodule

// File: tb/tb_traceback_unit.sv
// Scoreboard bench: a behavioural direction RAM feeds the unit, expected ops are
// queued per path and compared as the unit hands them over.
module tb_traceback_unit;
  localparam int N      = 4;
  localparam int LOG_N  = 2;
  localparam int ADDR_W = 8;
  localparam int BLK_W  = 6;

  logic              clk = 1'b0;
  logic              reset_i;
  logic              start;
  logic [ADDR_W-1:0] tb_x, tb_y;
  logic [N*5-1:0]    column_k0;
  logic [BLK_W-1:0]  mem_block_num;
  logic [ADDR_W-1:0] column_num;
  logic              op_valid;
  logic [1:0]        op;
  logic              op_ready;
  logic              busy, done;
  logic [ADDR_W:0]   path_len;

  logic [4:0] dir_mem [0:31][0:15];
  int n_checks = 0;
  int n_fail   = 0;
  int exp_q[$];
  int addr_log[$];
  logic busy_prev = 1'b0;
  logic acc_prev  = 1'b0;

  traceback_unit #(.N(N), .LOG_N(LOG_N), .ADDR_W(ADDR_W), .BLK_W(BLK_W)) dut (
    .clk(clk), .reset_i(reset_i), .start(start), .tb_x(tb_x), .tb_y(tb_y),
    .column_k0(column_k0), .mem_block_num(mem_block_num), .column_num(column_num),
    .op_valid(op_valid), .op(op), .op_ready(op_ready), .busy(busy), .done(done),
    .path_len(path_len)
  );

  always #5 clk = ~clk;

  // Direction RAM: one-cycle read latency, N rows per block.
  always @(posedge clk) begin
    for (int j = 0; j < N; j++)
      column_k0[j*5 +: 5] <= dir_mem[{mem_block_num[2:0], 2'(j)}][column_num[3:0]];
  end

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Scoreboard side: pop on every handshake; log the address of every ADDR cycle.
  always @(negedge clk) begin
    if (op_valid && op_ready) begin
      if (exp_q.size() == 0) check_eq("op_extra", 1, 0);
      else check_eq("op", int'(op), exp_q.pop_front());
    end
    if (reset_i && busy && (!busy_prev || acc_prev))
      addr_log.push_back(int'(mem_block_num) * 256 + int'(column_num));
    busy_prev <= busy;
    acc_prev  <= op_valid && op_ready;
  end

  task automatic clear_mem();
    for (int r = 0; r < 32; r++)
      for (int c = 0; c < 16; c++)
        dir_mem[r][c] = 5'd0;
  endtask

  task automatic run_path(input int x, input int y, input int exp_len,
                          input bit disturb, input bit hold);
    int cyc;
    bit seen;
    bit held;
    cyc = 0; seen = 1'b0; held = 1'b0;
    addr_log.delete();
    @(negedge clk);
    tb_x = ADDR_W'(x); tb_y = ADDR_W'(y); start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    while (!seen && cyc < 400) begin
      if (done) begin
        seen = 1'b1;
      end else if (hold && !held && op_valid) begin
        for (int k = 0; k < 5; k++) begin
          check_eq("hold_valid", int'(op_valid), 1);
          check_eq("hold_op", int'(op), (exp_q.size() > 0) ? exp_q[0] : -1);
          check_eq("hold_len", int'(path_len), 0);
          @(negedge clk);
        end
        held = 1'b1;
        @(posedge clk);
        #1 op_ready = 1'b1;
        @(negedge clk);
        cyc++;
      end else begin
        start = (disturb && cyc == 4);
        if (start) begin
          tb_x = 8'd4; tb_y = 8'd1;
        end
        @(negedge clk);
        cyc++;
      end
    end
    start = 1'b0;
    check_eq("done_seen", int'(seen), 1);
    check_eq("path_len", int'(path_len), exp_len);
    check_eq("busy_at_done", int'(busy), 1);
    check_eq("ops_left", exp_q.size(), 0);
    @(negedge clk);
    check_eq("done_pulse", int'(done), 0);
    check_eq("busy_after", int'(busy), 0);
    check_eq("len_held", int'(path_len), exp_len);
  endtask

  initial begin
    reset_i = 1'b0; start = 1'b0; op_ready = 1'b1; tb_x = 8'd0; tb_y = 8'd0;
    clear_mem();
    #1;
    check_eq("rst_busy", int'(busy), 0);
    check_eq("rst_valid", int'(op_valid), 0);
    check_eq("rst_len", int'(path_len), 0);
    repeat (2) @(negedge clk);
    reset_i = 1'b1;

    // Pure diagonal to the origin.
    clear_mem();
    dir_mem[3][3] = 5'd1; dir_mem[2][2] = 5'd1; dir_mem[1][1] = 5'd1;
    exp_q = '{0, 0, 0};
    run_path(3, 3, 3, 1'b0, 1'b0);

    // Short-gap deletion run, closing into a stop cell.
    clear_mem();
    dir_mem[1][4] = 5'b01010; dir_mem[1][3] = 5'b00010; dir_mem[1][2] = 5'b00000;
    exp_q = '{2, 2};
    run_path(4, 1, 2, 1'b0, 1'b0);
    check_eq("col_log_n", addr_log.size(), 3);
    if (addr_log.size() == 3) begin
      check_eq("col0", addr_log[0], 4);
      check_eq("col1", addr_log[1], 3);
      check_eq("col2", addr_log[2], 2);
    end

    // Long-gap insertion run across a block boundary.
    clear_mem();
    dir_mem[5][3] = 5'b10101; dir_mem[4][3] = 5'b10101;
    dir_mem[3][3] = 5'b00101; dir_mem[2][3] = 5'b00000;
    exp_q = '{1, 1, 1};
    run_path(3, 5, 3, 1'b0, 1'b0);
    check_eq("blk_log_n", addr_log.size(), 4);
    if (addr_log.size() == 4) begin
      check_eq("addr0", addr_log[0], 256 + 3);
      check_eq("addr1", addr_log[1], 256 + 3);
      check_eq("addr2", addr_log[2], 3);
      check_eq("addr3", addr_log[3], 3);
    end

    // Back-pressure on the first op.
    clear_mem();
    dir_mem[2][2] = 5'd1; dir_mem[1][1] = 5'd1;
    exp_q = '{0, 0};
    op_ready = 1'b0;
    run_path(2, 2, 2, 1'b0, 1'b1);
    op_ready = 1'b1;

    // Reset while waiting on the RAM, then an immediate-stop path.
    clear_mem();
    dir_mem[3][3] = 5'd1; dir_mem[2][2] = 5'd1; dir_mem[1][1] = 5'd1;
    dir_mem[1][3] = 5'b00011;
    exp_q = '{1};
    run_path(3, 1, 1, 1'b0, 1'b0);
    @(negedge clk);
    tb_x = 8'd3; tb_y = 8'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    reset_i = 1'b0;
    #1;
    check_eq("mid_rst_busy", int'(busy), 0);
    check_eq("mid_rst_valid", int'(op_valid), 0);
    check_eq("mid_rst_op", int'(op), 0);
    check_eq("mid_rst_done", int'(done), 0);
    check_eq("mid_rst_len", int'(path_len), 0);
    check_eq("mid_rst_blk", int'(mem_block_num), 0);
    check_eq("mid_rst_col", int'(column_num), 0);
    exp_q.delete();
    @(negedge clk);
    reset_i = 1'b1;
    run_path(0, 0, 0, 1'b0, 1'b0);

    // Second start while busy must be ignored.
    exp_q = '{0, 0, 0};
    run_path(3, 3, 3, 1'b1, 1'b0);
    repeat (3) @(negedge clk);
    check_eq("no_restart", int'(busy), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/traceback_unit.md
TRACEBACK_UNIT -- requirements
Module: traceback_unit

Interface
REQ-001 Parameter N, default `N: PE count; rows per direction-RAM block; power of two.
REQ-002 Parameter LOG_N, default `log_N: log2(N).
REQ-003 Parameter ADDR_W, default `ADDRESS_WIDTH: width of row/column coordinates.
REQ-004 Parameter BLK_W, default `MEM_AMOUNT_WIDTH: width of the block index.
REQ-005 clk  in  1  clock.
REQ-006 reset_i  in  1  reset, asynchronous, active-low.
REQ-007 start  in  1  one-cycle pulse; begin traceback; ignored unless state is IDLE.
REQ-008 tb_x  in  ADDR_W  column of the best cell; sampled on start.
REQ-009 tb_y  in  ADDR_W  row of the best cell; sampled on start.
REQ-010 column_k0  in  N*5  direction column returned by the direction RAMs; lane j at bits [j*5+:5]; valid 1 cycle after the address.
REQ-011 mem_block_num  out  BLK_W  block index read = row >> LOG_N.
REQ-012 column_num  out  ADDR_W  column address read.
REQ-013 op_valid  out  1  op holds an alignment operation.
REQ-014 op  out  2  0=match/mismatch, 1=insertion (vertical), 2=deletion (horizontal), 3 unused.
REQ-015 op_ready  in  1  consumer accepts op when op_valid&op_ready.
REQ-016 busy  out  1  high from the cycle after an accepted start to the cycle done is high, inclusive.
REQ-017 done  out  1  one-cycle pulse at end of traceback.
REQ-018 path_len  out  ADDR_W+1  ops emitted; held after done.

Function
REQ-019 Direction code: [2:0] H source (0 stop, 1 diag, 2 E, 3 F, 4 E_hat, 5 F_hat, 6/7 treated as stop); bit3 short-gap extend; bit4 long-gap extend.
REQ-020 FSM states: IDLE, ADDR, WAIT, DECODE, EMIT, DONE.
REQ-021 IDLE: on start, latch x=tb_x, y=tb_y, matrix=H, path_len=0; go to ADDR next cycle.
REQ-022 ADDR: drive column_num=x, mem_block_num=y>>LOG_N; go to WAIT. Both outputs hold through WAIT and DECODE.
REQ-023 WAIT: go to DECODE; one-cycle RAM latency.
REQ-024 DECODE: select lane y[LOG_N-1:0]. If x==0, y==0, or the selected code gives stop in matrix H, go to DONE. Otherwise compute the move and the next matrix, then go to EMIT.
REQ-025 Move in matrix H by source:
- diag: op 0, x-1, y-1, stay in H.
- E / E_hat: enter that matrix without moving; re-evaluate in the same DECODE cycle.
- F / F_hat: same as E / E_hat.
REQ-026 Move in matrix E / E_hat: op 2, x-1. Stay in the matrix if bit3 (E) / bit4 (E_hat) is set; else return to H.
REQ-027 Move in matrix F / F_hat: op 1, y-1. Extend flag as in REQ-026.
REQ-028 A gap step that would take x or y below 0 terminates: go to DONE without emitting.
REQ-029 EMIT: assert op_valid with a stable op. On op_ready, path_len+1 and coordinates update; go to ADDR. op_valid holds while op_ready is low.
REQ-030 DONE: done=1 for one cycle; return to IDLE. path_len holds until the next accepted start.
REQ-031 Throughput: at most 1 op per 4 cycles. Path latency = 4 cycles per op plus 3 cycles, with op_ready held high.
REQ-032 A start while busy is ignored and has no side effects.
REQ-033 Coordinate decrement never wraps (guaranteed by REQ-024 and REQ-028).

Reset
REQ-034 reset_i low, at any time including mid-traceback:
- state=IDLE; x=y=0; matrix=H.
- op_valid=0, op=0, done=0, busy=0, path_len=0.
- mem_block_num=0, column_num=0.
REQ-035 After reset release, the first start is accepted normally.

Structure
REQ-036 Direction-field positions, H-source codes, op codes and FSM encoding are defined in define.v alongside `N, `log_N, `DIRECTION_WIDTH.
REQ-037 One sub-module, tb_dir_decode: combinational decode of (code, matrix) into (stop, op, dx, dy, next matrix).

Verification
REQ-038 tb_x=3, tb_y=3; codes at (3,3),(2,2),(1,1) = diag; (0,0) reached -> ops 0,0,0; path_len=3; done pulse.
REQ-039 tb_x=4, tb_y=1, N=4:
- (4,1) = E with bit3 set; (3,1) = E with bit3 clear; (2,1) = stop.
- Required: ops 2,2; path_len=2; column_num sequence 4,3,2.
REQ-040 tb_y=5, N=4, F_hat path with bit4 set across the block boundary: mem_block_num goes 1 -> 0 as y goes 4 -> 3; lane switches 0 -> 3; ops all 1.
REQ-041 op_ready held low for 5 cycles during EMIT: op_valid and op stable throughout; exactly one op counted on release.
REQ-042 reset_i asserted while in WAIT mid-path: all outputs reach REQ-034 values immediately; a new start with tb_x=tb_y=0 gives done with path_len=0 and no op_valid.
REQ-043 start pulsed again during busy: ignored; op stream and path_len identical to an undisturbed run.
